gemm_host_dma: RTL and testbench

- Host-side data mover for gemm_accelerator_top.
- Accepts one job command (M,K,N) and a valid/ready stream of int8 elements: A in row-major order, then B in row-major order. Writes them into SRAM A and SRAM B.
- Pulses the accelerator's start, waits for done, then reads SRAM C (row-major, M*N words) and streams it out with valid/ready.
- Holds the write ports of A/B and the read port of C; top-level muxes the SRAM ports using mem_owner_o.

---
 rtl/gemm_host_dma.sv | 195 +++++++++++++++++++
 tb/tb_gemm_host_dma.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_host_dma.sv
// gemm_host_dma: host-side data mover for the GEMM accelerator.
// Loads A then B from an element stream into their SRAMs, starts the
// accelerator, waits for done, then streams C out through a 2-entry FIFO.
// Optional feature: define GEMM_HOST_DMA_WDOG_EN to abort jobs whose WAIT
// phase exceeds WdogCycles cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a command; bad commands pulse cmd_err_o
// LOAD_A  | write M*K stream elements into SRAM A
// LOAD_B  | write K*N stream elements into SRAM B
// START   | one-cycle accelerator start pulse, SRAMs handed over
// WAIT    | accelerator running, waiting for acc_done_i
// DRAIN   | read M*N words of SRAM C and stream them out
module gemm_host_dma #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int DataDepth     = 4096,
    parameter int AddrWidth     = $clog2(DataDepth),
    parameter int SizeAddrWidth = 8,
    parameter int WdogCycles    = 65536
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [SizeAddrWidth-1:0] cmd_m_i,
    input  logic [SizeAddrWidth-1:0] cmd_k_i,
    input  logic [SizeAddrWidth-1:0] cmd_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [InDataWidth-1:0]   in_data_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic                     sram_a_we_o,
    output logic [InDataWidth-1:0]   sram_a_wdata_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic                     sram_b_we_o,
    output logic [InDataWidth-1:0]   sram_b_wdata_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
    output logic                     acc_start_o,
    output logic [SizeAddrWidth-1:0] acc_m_o,
    output logic [SizeAddrWidth-1:0] acc_k_o,
    output logic [SizeAddrWidth-1:0] acc_n_o,
    input  logic                     acc_done_i,
    output logic                     mem_owner_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OutDataWidth-1:0]  out_data_o,
    output logic                     out_last_o,
    output logic                     cmd_err_o,
    output logic                     busy_o
);

    localparam int ProdWidth = 2 * SizeAddrWidth;
    localparam logic [ProdWidth-1:0] DepthP = ProdWidth'(DataDepth);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [SizeAddrWidth-1:0] m_q, k_q, n_q;
    logic [ProdWidth-1:0]     idx_q, out_idx_q;
    logic                     rd_pend_q, err_q;
    logic [OutDataWidth-1:0]  fifo_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               fifo_cnt_q;

    logic [ProdWidth-1:0] cmd_mk, cmd_kn, cmd_mn, prod_mk, prod_kn, prod_mn;
    logic cmd_bad, cmd_fire, in_fire, pop, rd_issue, last_out;
    logic reject, wdog_expire;
    logic [1:0] fifo_free;

    assign cmd_mk  = ProdWidth'(cmd_m_i) * ProdWidth'(cmd_k_i);
    assign cmd_kn  = ProdWidth'(cmd_k_i) * ProdWidth'(cmd_n_i);
    assign cmd_mn  = ProdWidth'(cmd_m_i) * ProdWidth'(cmd_n_i);
    assign prod_mk = ProdWidth'(m_q) * ProdWidth'(k_q);
    assign prod_kn = ProdWidth'(k_q) * ProdWidth'(n_q);
    assign prod_mn = ProdWidth'(m_q) * ProdWidth'(n_q);

    assign cmd_bad = (cmd_m_i == '0) || (cmd_k_i == '0) || (cmd_n_i == '0) ||
                     (cmd_mk > DepthP) || (cmd_kn > DepthP) || (cmd_mn > DepthP);

    assign cmd_ready_o = (state_q == S_IDLE);
    assign in_ready_o  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign in_fire     = in_valid_i && in_ready_o;

    assign sram_a_addr_o  = idx_q[AddrWidth-1:0];
    assign sram_b_addr_o  = idx_q[AddrWidth-1:0];
    assign sram_c_addr_o  = idx_q[AddrWidth-1:0];
    assign sram_a_we_o    = in_valid_i && (state_q == S_LOAD_A);
    assign sram_b_we_o    = in_valid_i && (state_q == S_LOAD_B);
    assign sram_a_wdata_o = in_data_i;
    assign sram_b_wdata_o = in_data_i;

    assign acc_start_o = (state_q == S_START);
    assign acc_m_o     = m_q;
    assign acc_k_o     = k_q;
    assign acc_n_o     = n_q;
    assign mem_owner_o = (state_q != S_START) && (state_q != S_WAIT);
    assign busy_o      = (state_q != S_IDLE);
    assign cmd_err_o   = err_q;

    // Output FIFO head; a slot freed by this cycle's pop counts as free so
    // the read pipeline sustains one word per cycle.
    assign out_valid_o = (fifo_cnt_q != 2'd0);
    assign out_data_o  = fifo_q[rd_ptr_q];
    assign last_out    = (out_idx_q == prod_mn - 1'b1);
    assign out_last_o  = out_valid_o && last_out;
    assign pop         = out_valid_o && out_ready_i;
    assign fifo_free   = 2'd2 - fifo_cnt_q + {1'b0, pop};
    assign rd_issue    = (state_q == S_DRAIN) && (idx_q < prod_mn) &&
                         (fifo_free > {1'b0, rd_pend_q});

`ifdef GEMM_HOST_DMA_WDOG_EN
    localparam int WdogWidth = $clog2(WdogCycles + 1);
    logic [WdogWidth-1:0] wdog_q;

    // Watchdog down-counter, loaded in START so it is fresh on WAIT entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                wdog_q <= '0;
        else if (state_q == S_START)                wdog_q <= WdogWidth'(WdogCycles - 1);
        else if (state_q == S_WAIT && wdog_q != '0) wdog_q <= wdog_q - 1'b1;
    end
`endif

    // Next-state logic and reject / abort detection.
    always_comb begin
        state_d     = state_q;
        reject      = 1'b0;
        wdog_expire = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_fire) begin
                if (cmd_bad) reject  = 1'b1;
                else         state_d = S_LOAD_A;
            end
            S_LOAD_A: if (in_fire && idx_q == prod_mk - 1'b1) state_d = S_LOAD_B;
            S_LOAD_B: if (in_fire && idx_q == prod_kn - 1'b1) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (acc_done_i) state_d = S_DRAIN;
`ifdef GEMM_HOST_DMA_WDOG_EN
                else if (wdog_q == '0) begin
                    state_d     = S_IDLE;
                    wdog_expire = 1'b1;
                end
`endif
            end
            S_DRAIN:  if (pop && last_out) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Job sizes, address counter (restarts on every state change) and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q <= '0; k_q <= '0; n_q <= '0;
            idx_q <= '0; out_idx_q <= '0; rd_pend_q <= 1'b0; err_q <= 1'b0;
        end else begin
            if (cmd_fire && !cmd_bad) begin
                m_q <= cmd_m_i; k_q <= cmd_k_i; n_q <= cmd_n_i;
            end
            if (state_d != state_q)     idx_q <= '0;
            else if (in_fire || rd_issue) idx_q <= idx_q + 1'b1;
            if (state_q != S_DRAIN) out_idx_q <= '0;
            else if (pop)           out_idx_q <= out_idx_q + 1'b1;
            rd_pend_q <= rd_issue;
            err_q     <= reject || wdog_expire;
        end
    end

    // Output FIFO: SRAM C data lands one cycle after its read was issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q[0] <= '0; fifo_q[1] <= '0;
            wr_ptr_q <= 1'b0; rd_ptr_q <= 1'b0; fifo_cnt_q <= 2'd0;
        end else begin
            if (rd_pend_q) begin
                fifo_q[wr_ptr_q] <= sram_c_rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_gemm_host_dma.sv
// Directed testbench for gemm_host_dma with SRAM and accelerator stubs.
// Build with GEMM_HOST_DMA_WDOG_EN defined to include the watchdog scenario.
module tb_gemm_host_dma;
    localparam int IW = 8, OW = 32, DD = 4096, AW = 12, SW = 8;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic cmd_valid_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0, acc_en = 1'b1;
    logic [SW-1:0] cmd_m_i = '0, cmd_k_i = '0, cmd_n_i = '0;
    logic [IW-1:0] in_data_i = '0;
    logic cmd_ready_o, in_ready_o, sram_a_we_o, sram_b_we_o, acc_start_o, acc_done_i;
    logic mem_owner_o, out_valid_o, out_last_o, cmd_err_o, busy_o;
    logic [AW-1:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic [IW-1:0] sram_a_wdata_o, sram_b_wdata_o;
    logic [OW-1:0] sram_c_rdata_i = '0, out_data_o;
    logic [SW-1:0] acc_m_o, acc_k_o, acc_n_o;

    logic [IW-1:0] mem_a [DD];
    logic [IW-1:0] mem_b [DD];
    logic [OW-1:0] mem_c [DD];
    int a_wr_cnt = 0, b_wr_cnt = 0, start_cnt = 0, acc_cd = 0;
    int checks = 0, errors = 0;
    logic [OW-1:0] cap_data [64];
    logic          cap_last [64];
    int            cap_cyc  [64];
    int            ncap;

    gemm_host_dma #(.WdogCycles(100)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_m_i(cmd_m_i), .cmd_k_i(cmd_k_i), .cmd_n_i(cmd_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .sram_a_addr_o(sram_a_addr_o), .sram_a_we_o(sram_a_we_o), .sram_a_wdata_o(sram_a_wdata_o),
        .sram_b_addr_o(sram_b_addr_o), .sram_b_we_o(sram_b_we_o), .sram_b_wdata_o(sram_b_wdata_o),
        .sram_c_addr_o(sram_c_addr_o), .sram_c_rdata_i(sram_c_rdata_i),
        .acc_start_o(acc_start_o), .acc_m_o(acc_m_o), .acc_k_o(acc_k_o), .acc_n_o(acc_n_o),
        .acc_done_i(acc_done_i), .mem_owner_o(mem_owner_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .cmd_err_o(cmd_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // SRAM and accelerator stubs; done fires 5 cycles after start.
    always @(posedge clk_i) begin
        if (sram_a_we_o) begin mem_a[sram_a_addr_o] <= sram_a_wdata_o; a_wr_cnt <= a_wr_cnt + 1; end
        if (sram_b_we_o) begin mem_b[sram_b_addr_o] <= sram_b_wdata_o; b_wr_cnt <= b_wr_cnt + 1; end
        sram_c_rdata_i <= mem_c[sram_c_addr_o];
        if (acc_start_o) start_cnt <= start_cnt + 1;
        if (!rst_ni)          acc_cd <= 0;
        else if (acc_start_o) acc_cd <= 5;
        else if (acc_cd != 0) acc_cd <= acc_cd - 1;
    end
    assign acc_done_i = acc_en && (acc_cd == 1);

    function automatic logic [OW-1:0] cval(input int i);
        return 32'hC000_0000 + 32'(i) * 32'd17;
    endfunction

    task automatic do_reset;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic send_cmd(input int m, input int k, input int n);
        cmd_m_i = SW'(m); cmd_k_i = SW'(k); cmd_n_i = SW'(n); cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_elems(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            int t = 0;
            in_data_i = IW'(first + i); in_valid_i = 1'b1;
            while (!in_ready_o && t < 50) begin @(negedge clk_i); t++; end
            if (!in_ready_o) begin
                checks++; errors++;
                $display("FAIL in_ready timeout: element %0d not accepted within 50 cycles", i);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int n, input int mode);
        ncap = 0;
        for (int cyc = 0; cyc < 400 && ncap < n; cyc++) begin
            logic r;
            r = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (out_valid_o && r) begin
                cap_data[ncap] = out_data_o; cap_last[ncap] = out_last_o; cap_cyc[ncap] = cyc;
                ncap++;
            end
            out_ready_i = r;
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        if (ncap < n) begin
            checks++; errors++;
            $display("FAIL drain timeout: got %0d words, expected %0d", ncap, n);
        end
    endtask

    task automatic check_stream(input string name, input int n);
        for (int i = 0; i < n && i < ncap; i++) begin
            checks++;
            if (cap_data[i] !== cval(i)) begin
                errors++;
                $display("FAIL %s data[%0d]: got %h expected %h", name, i, cap_data[i], cval(i));
            end
            checks++;
            if (cap_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s last[%0d]: got %b expected %b", name, i, cap_last[i], (i == n - 1));
            end
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid_o); end
        checks++; if (mem_owner_o !== 1'b1) begin errors++; $display("FAIL reset mem_owner: got %b expected 1", mem_owner_o); end
        checks++; if ({sram_a_we_o, sram_b_we_o, acc_start_o, cmd_err_o, busy_o} !== 5'b0) begin
            errors++; $display("FAIL reset we/start/err/busy: got %b expected 00000",
                               {sram_a_we_o, sram_b_we_o, acc_start_o, cmd_err_o, busy_o});
        end
        do_reset();
    endtask

    task automatic test_basic_job;
        int s0;
        s0 = start_cnt;
        send_cmd(2, 3, 2);
        checks++; if (busy_o !== 1'b1 || cmd_err_o !== 1'b0) begin errors++; $display("FAIL basic accept: busy=%b err=%b expected 1/0", busy_o, cmd_err_o); end
        send_elems(1, 6);
        send_elems(7, 6);
        checks++; if (acc_start_o !== 1'b1 || mem_owner_o !== 1'b0) begin
            errors++; $display("FAIL basic start: start=%b owner=%b expected 1/0", acc_start_o, mem_owner_o);
        end
        checks++; if (acc_m_o !== 8'd2 || acc_k_o !== 8'd3 || acc_n_o !== 8'd2) begin
            errors++; $display("FAIL basic sizes: got %0d/%0d/%0d expected 2/3/2", acc_m_o, acc_k_o, acc_n_o);
        end
        drain(4, 0);
        for (int i = 0; i < 6; i++) begin
            checks++; if (mem_a[i] !== IW'(i + 1)) begin errors++; $display("FAIL basic sram_a[%0d]: got %0d expected %0d", i, mem_a[i], i + 1); end
            checks++; if (mem_b[i] !== IW'(i + 7)) begin errors++; $display("FAIL basic sram_b[%0d]: got %0d expected %0d", i, mem_b[i], i + 7); end
        end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic start count: got %0d expected 1", start_cnt - s0); end
        check_stream("basic", 4);
        checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL basic end idle: busy=%b ready=%b expected 0/1", busy_o, cmd_ready_o); end
    endtask

    task automatic test_rejects;
        int w0;
        w0 = a_wr_cnt;
        send_cmd(0, 3, 2);
        checks++; if (cmd_err_o !== 1'b1) begin errors++; $display("FAIL reject m0 err: got %b expected 1", cmd_err_o); end
        in_valid_i = 1'b1; in_data_i = 8'hEE;
        @(negedge clk_i);
        checks++; if (cmd_err_o !== 1'b0) begin errors++; $display("FAIL reject m0 pulse width: got %b expected 0", cmd_err_o); end
        repeat (2) @(negedge clk_i);
        in_valid_i = 1'b0;
        checks++; if (a_wr_cnt !== w0 || busy_o !== 1'b0) begin errors++; $display("FAIL reject m0 writes: got %0d busy %b expected 0/0", a_wr_cnt - w0, busy_o); end
        send_cmd(64, 65, 1);
        checks++; if (cmd_err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL reject 4160 err/busy: got %b/%b expected 1/0", cmd_err_o, busy_o); end
        @(negedge clk_i);
        send_cmd(64, 64, 64);
        checks++; if (cmd_err_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL accept 4096 err/busy/in_ready: got %b/%b/%b expected 0/1/1", cmd_err_o, busy_o, in_ready_o);
        end
        do_reset();
    endtask

    task automatic test_backpressure;
        send_cmd(4, 1, 4); send_elems(20, 4); send_elems(30, 4);
        drain(16, 1);
        check_stream("bp_toggle", 16);
        send_cmd(4, 1, 4); send_elems(20, 4); send_elems(30, 4);
        drain(16, 0);
        check_stream("bp_full", 16);
        checks++; if (ncap == 16 && cap_cyc[15] - cap_cyc[0] !== 15) begin
            errors++; $display("FAIL full throughput span: got %0d cycles expected 15", cap_cyc[15] - cap_cyc[0]);
        end
    endtask

    task automatic test_reset_mid_job;
        int t;
        send_cmd(2, 2, 2); send_elems(40, 4); send_elems(50, 1);
        rst_ni = 1'b0; #1;
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset in LOAD_B: ready=%b busy=%b valid=%b in_ready=%b expected 1/0/0/0", cmd_ready_o, busy_o, out_valid_o, in_ready_o);
        end
        @(negedge clk_i); rst_ni = 1'b1; @(negedge clk_i);
        send_cmd(2, 2, 2); send_elems(40, 4); send_elems(50, 4);
        t = 0;
        while (!out_valid_o && t < 50) begin @(negedge clk_i); t++; end
        repeat (3) @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL drain reached: out_valid got %b expected 1", out_valid_o); end
        rst_ni = 1'b0; #1;
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset in DRAIN: valid=%b busy=%b expected 0/0", out_valid_o, busy_o);
        end
        @(negedge clk_i); rst_ni = 1'b1; @(negedge clk_i);
        send_cmd(1, 1, 1); send_elems(5, 1); send_elems(6, 1);
        drain(1, 0);
        checks++; if (mem_a[0] !== 8'd5 || mem_b[0] !== 8'd6) begin errors++; $display("FAIL post-reset sram: got %0d/%0d expected 5/6", mem_a[0], mem_b[0]); end
        check_stream("post_reset", 1);
    endtask

`ifdef GEMM_HOST_DMA_WDOG_EN
    task automatic test_watchdog;
        int t, n;
        acc_en = 1'b0;
        send_cmd(1, 1, 1); send_elems(1, 1); send_elems(2, 1);
        t = 0;
        while (!acc_start_o && t < 50) begin @(negedge clk_i); t++; end
        n = 0;
        while (!cmd_err_o && n < 300) begin @(negedge clk_i); n++; end
        checks++; if (n !== 101) begin errors++; $display("FAIL watchdog delay: got %0d cycles after start expected 101", n); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL watchdog idle: busy=%b valid=%b expected 0/0", busy_o, out_valid_o); end
        acc_en = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < DD; i++) mem_c[i] = cval(i);
        test_reset();
        test_basic_job();
        test_rejects();
        test_backpressure();
        test_reset_mid_job();
`ifdef GEMM_HOST_DMA_WDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
